// File: rtl/pipeline_stall_controller_pkg.sv
// Shared constants for the pipeline hold/flush sequencer: FSM encodings,
// default multi-cycle latencies and the NOP instruction word.
package pipeline_stall_controller_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MULDIV  = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;

    localparam int DEF_MUL_LAT = 3;
    localparam int DEF_DIV_LAT = 33;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Counter preload so that a latency-L operation stalls for L-1 cycles.
    function automatic logic [5:0] lat_preload(input int lat);
        return (lat > 1) ? 6'(lat - 2) : 6'd0;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_occupancy.sv
// Down-counter tracking how many more EX cycles a MUL/DIV keeps the stage busy.
// Frozen while memory is busy so the remaining count survives a freeze.
module muldiv_occupancy_counter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       dec,
    input  logic       freeze,
    output logic       zero
);

    logic [5:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= 6'd0;
        end else if (!freeze) begin
            if (load) begin
                cnt <= load_val;
            end else if (dec && (cnt != 6'd0)) begin
                cnt <= cnt - 6'd1;
            end
        end
    end

    assign zero = (cnt == 6'd0);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central hold/flush sequencer for the 5-stage pipeline registers, plus a
// saturating count of cycles in which the PC is held.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IMEM_BUSYWAIT,
    input  logic             DMEM_BUSYWAIT,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic             EX_MEMREAD,
    input  logic [4:0]       EX_RD,
    input  logic             EX_IS_MUL,
    input  logic             EX_IS_DIV,
    input  logic             EX_BRANCH_TAKEN,
    output logic             PC_HOLD,
    output logic             IFID_HOLD,
    output logic             IFID_FLUSH,
    output logic             IDEX_HOLD,
    output logic             IDEX_BUBBLE,
    output logic             EXMEM_HOLD,
    output logic             EXMEM_BUBBLE,
    output logic             MEMWB_HOLD,
    output logic [CNT_W-1:0] STALL_CYCLES
);

    localparam logic       MUL_STALLS = (MUL_LAT > 1);
    localparam logic       DIV_STALLS = (DIV_LAT > 1);
    localparam logic [5:0] MUL_LD     = lat_preload(MUL_LAT);
    localparam logic [5:0] DIV_LD     = lat_preload(DIV_LAT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [1:0] state, ret_state, eval_state, state_nxt;
    logic       busy, md_start, load_use, cnt_zero, cnt_load, cnt_dec;
    logic [5:0] ld_val;
    logic       pc_h, ifid_h, ifid_f, idex_h, idex_b, exmem_h, exmem_b, memwb_h;

    assign busy       = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
    // Leaving MEMWAIT resumes whatever was interrupted in the very same cycle.
    assign eval_state = (state == ST_MEMWAIT) ? ret_state : state;
    assign md_start   = (EX_IS_DIV && DIV_STALLS) || (EX_IS_MUL && MUL_STALLS);
    assign ld_val     = (EX_IS_DIV && DIV_STALLS) ? DIV_LD : MUL_LD;
    assign load_use   = EX_MEMREAD && (EX_RD != 5'd0) &&
                        ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                         (ID_USES_RS2 && (ID_RS2 == EX_RD)));

    always_comb begin
        state_nxt = eval_state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        pc_h      = 1'b0;
        ifid_h    = 1'b0;
        ifid_f    = 1'b0;
        idex_h    = 1'b0;
        idex_b    = 1'b0;
        exmem_h   = 1'b0;
        exmem_b   = 1'b0;
        memwb_h   = 1'b0;
        if (busy) begin
            {pc_h, ifid_h, idex_h, exmem_h, memwb_h} = 5'b11111;
            state_nxt = ST_MEMWAIT;
        end else if (eval_state == ST_MULDIV) begin
            if (!cnt_zero) begin
                {pc_h, ifid_h, idex_h, exmem_b} = 4'b1111;
                cnt_dec = 1'b1;
            end else begin
                state_nxt = ST_RUN;
            end
        end else if (md_start) begin
            {pc_h, ifid_h, idex_h, exmem_b} = 4'b1111;
            cnt_load  = 1'b1;
            state_nxt = ST_MULDIV;
        end else if (EX_BRANCH_TAKEN) begin
            // The ID instruction is squashed anyway, so a load-use hold is moot.
            {ifid_f, idex_b} = 2'b11;
        end else if (load_use) begin
            {pc_h, ifid_h, idex_b} = 3'b111;
        end
    end

    assign PC_HOLD      = pc_h    & ~RESET;
    assign IFID_HOLD    = ifid_h  & ~RESET;
    assign IFID_FLUSH   = ifid_f  & ~RESET;
    assign IDEX_HOLD    = idex_h  & ~RESET;
    assign IDEX_BUBBLE  = idex_b  & ~RESET;
    assign EXMEM_HOLD   = exmem_h & ~RESET;
    assign EXMEM_BUBBLE = exmem_b & ~RESET;
    assign MEMWB_HOLD   = memwb_h & ~RESET;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= ST_RUN;
            ret_state    <= ST_RUN;
            STALL_CYCLES <= '0;
        end else begin
            state <= state_nxt;
            if (busy) begin
                ret_state <= eval_state;
            end
            if (pc_h) begin
                STALL_CYCLES <= sat_inc(STALL_CYCLES);
            end
        end
    end

    muldiv_occupancy_counter u_occ (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (cnt_load),
        .load_val (ld_val),
        .dec      (cnt_dec),
        .freeze   (busy),
        .zero     (cnt_zero)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios plus random traffic,
// both checked against a schedule-queue reference model.
module tb_pipeline_stall_controller;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       IMEM_BUSYWAIT, DMEM_BUSYWAIT;
    logic [4:0] ID_RS1, ID_RS2, EX_RD;
    logic       ID_USES_RS1, ID_USES_RS2, EX_MEMREAD;
    logic       EX_IS_MUL, EX_IS_DIV, EX_BRANCH_TAKEN;

    logic        PC_HOLD, IFID_HOLD, IFID_FLUSH, IDEX_HOLD, IDEX_BUBBLE;
    logic        EXMEM_HOLD, EXMEM_BUBBLE, MEMWB_HOLD;
    logic [31:0] STALL_CYCLES;
    logic        s_pc, s_ifidh, s_ifidf, s_idexh, s_idexb, s_exmemh, s_exmemb, s_memwbh;
    logic [3:0]  s_stall;

    pipeline_stall_controller #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_MEMREAD(EX_MEMREAD), .EX_RD(EX_RD), .EX_IS_MUL(EX_IS_MUL), .EX_IS_DIV(EX_IS_DIV),
        .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .PC_HOLD(PC_HOLD), .IFID_HOLD(IFID_HOLD),
        .IFID_FLUSH(IFID_FLUSH), .IDEX_HOLD(IDEX_HOLD), .IDEX_BUBBLE(IDEX_BUBBLE),
        .EXMEM_HOLD(EXMEM_HOLD), .EXMEM_BUBBLE(EXMEM_BUBBLE), .MEMWB_HOLD(MEMWB_HOLD),
        .STALL_CYCLES(STALL_CYCLES)
    );

    pipeline_stall_controller #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RESET(RESET), .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_MEMREAD(EX_MEMREAD), .EX_RD(EX_RD), .EX_IS_MUL(EX_IS_MUL), .EX_IS_DIV(EX_IS_DIV),
        .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .PC_HOLD(s_pc), .IFID_HOLD(s_ifidh),
        .IFID_FLUSH(s_ifidf), .IDEX_HOLD(s_idexh), .IDEX_BUBBLE(s_idexb),
        .EXMEM_HOLD(s_exmemh), .EXMEM_BUBBLE(s_exmemb), .MEMWB_HOLD(s_memwbh),
        .STALL_CYCLES(s_stall)
    );

    always #5 CLK = ~CLK;

    // Bit order: PC_HOLD, IFID_HOLD, IFID_FLUSH, IDEX_HOLD, IDEX_BUBBLE, EXMEM_HOLD, EXMEM_BUBBLE, MEMWB_HOLD
    localparam logic [7:0] P_FREEZE = 8'b1101_0101;
    localparam logic [7:0] P_MDSTL  = 8'b1101_0010;
    localparam logic [7:0] P_BRANCH = 8'b0010_1000;
    localparam logic [7:0] P_LDUSE  = 8'b1100_1000;

    logic [7:0] ctrl, s_ctrl, last;
    assign ctrl   = {PC_HOLD, IFID_HOLD, IFID_FLUSH, IDEX_HOLD, IDEX_BUBBLE, EXMEM_HOLD, EXMEM_BUBBLE, MEMWB_HOLD};
    assign s_ctrl = {s_pc, s_ifidh, s_ifidf, s_idexh, s_idexb, s_exmemh, s_exmemb, s_memwbh};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: each pending entry is one future non-frozen EX cycle of an
    // in-flight MUL/DIV (1 = still occupied, 0 = result leaves).
    bit          sched[$];
    logic [31:0] m_cnt;
    logic [3:0]  m_sat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int op_latency();
        if (EX_IS_DIV && DIV_LAT > 1) return DIV_LAT;
        if (EX_IS_MUL && MUL_LAT > 1) return MUL_LAT;
        return 1;
    endfunction

    function automatic logic [7:0] model_ctrl();
        logic lu;
        if (RESET) return 8'h00;
        if (IMEM_BUSYWAIT || DMEM_BUSYWAIT) return P_FREEZE;
        if (sched.size() != 0) return sched[0] ? P_MDSTL : 8'h00;
        if (op_latency() > 1) return P_MDSTL;
        if (EX_BRANCH_TAKEN) return P_BRANCH;
        lu = EX_MEMREAD && (EX_RD != 0) &&
             ((ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD));
        return lu ? P_LDUSE : 8'h00;
    endfunction

    task automatic model_reset();
        sched.delete();
        m_cnt = 0;
        m_sat = 0;
    endtask

    task automatic model_edge(input logic [7:0] e);
        int lat;
        if (RESET) begin
            model_reset();
            return;
        end
        if (e[7]) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_sat != 4'hF) m_sat = m_sat + 1;
        end
        if (IMEM_BUSYWAIT || DMEM_BUSYWAIT) return;
        if (sched.size() != 0) begin
            void'(sched.pop_front());
        end else begin
            lat = op_latency();
            if (lat > 1) begin
                for (int i = 0; i < lat - 2; i++) sched.push_back(1'b1);
                sched.push_back(1'b0);
            end
        end
    endtask

    // Entered just after a falling edge with inputs already applied.
    task automatic tick();
        logic [7:0] e;
        #1;
        e = model_ctrl();
        chk("ctrl", {24'd0, ctrl}, {24'd0, e});
        chk("ctrl_sat_inst", {24'd0, s_ctrl}, {24'd0, e});
        chk("hold_vs_bubble", {31'd0, (IFID_HOLD & IFID_FLUSH) | (IDEX_HOLD & IDEX_BUBBLE) |
                                      (EXMEM_HOLD & EXMEM_BUBBLE)}, 32'd0);
        last = ctrl;
        @(posedge CLK);
        model_edge(e);
        #1;
        chk("stall_cycles", STALL_CYCLES, m_cnt);
        chk("stall_cycles_sat", {28'd0, s_stall}, {28'd0, m_sat});
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        IMEM_BUSYWAIT = 0; DMEM_BUSYWAIT = 0;
        ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
        EX_MEMREAD = 0; EX_RD = 0; EX_IS_MUL = 0; EX_IS_DIV = 0; EX_BRANCH_TAKEN = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    int stall_len, memwb_len;
    logic [31:0] base;

    initial begin
        clear_inputs();
        last = 8'h00;
        m_cnt = 0;
        m_sat = 0;
        RESET = 1'b1;
        EX_IS_DIV = 1'b1;
        #2;
        chk("reset_ctrl", {24'd0, ctrl}, 32'd0);
        chk("reset_stall", STALL_CYCLES, 32'd0);
        EX_IS_DIV = 1'b0;
        do_reset();

        // DIV occupies EX for 32 stall cycles, released on the 33rd.
        EX_IS_DIV = 1'b1;
        stall_len = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (last[7]) stall_len++;
            else break;
        end
        EX_IS_DIV = 1'b0;
        chk("div_stall_len", stall_len, 32'd32);
        chk("div_stall_count", STALL_CYCLES, 32'd32);
        chk("sat_holds_at_F", {28'd0, s_stall}, 32'h0000_000F);
        tick();
        chk("after_div_idle", {24'd0, last}, 32'd0);

        // Load-use on rs2, then the bubble clears it; x0 never stalls.
        EX_MEMREAD = 1; EX_RD = 5'd5; ID_RS1 = 5'd3; ID_USES_RS1 = 1; ID_RS2 = 5'd5; ID_USES_RS2 = 1;
        tick();
        chk("load_use", {24'd0, last}, {24'd0, P_LDUSE});
        EX_MEMREAD = 0;
        tick();
        chk("load_use_done", {24'd0, last}, 32'd0);
        EX_MEMREAD = 1; EX_RD = 5'd0; ID_RS2 = 5'd0;
        tick();
        chk("load_use_x0", {24'd0, last}, 32'd0);

        // Branch overrides a simultaneous load-use.
        EX_RD = 5'd5; ID_RS2 = 5'd5; EX_BRANCH_TAKEN = 1;
        tick();
        chk("branch_over_lu", {24'd0, last}, {24'd0, P_BRANCH});
        EX_BRANCH_TAKEN = 0; EX_MEMREAD = 0;
        tick();
        chk("branch_done", {24'd0, last}, 32'd0);

        // MUL interrupted by four data-memory busy cycles.
        clear_inputs();
        base = STALL_CYCLES;
        EX_IS_MUL = 1;
        tick();
        stall_len = last[7] ? 1 : 0;
        memwb_len = 0;
        EX_IS_MUL = 0;
        DMEM_BUSYWAIT = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (last[7]) stall_len++;
            if (last[0]) memwb_len++;
        end
        DMEM_BUSYWAIT = 0;
        EX_IS_MUL = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last[7]) stall_len++;
            else break;
        end
        EX_IS_MUL = 0;
        chk("mul_busy_stall_len", stall_len, MUL_LAT - 1 + 4);
        chk("mul_busy_memwb", memwb_len, 32'd4);
        chk("mul_busy_count", STALL_CYCLES - base, MUL_LAT - 1 + 4);

        // Reset mid-DIV aborts immediately; a fresh DIV gets its full stall.
        EX_IS_DIV = 1;
        tick();
        EX_IS_DIV = 0;
        for (int i = 0; i < 10; i++) tick();
        RESET = 1'b1;
        #1;
        chk("reset_mid_div_ctrl", {24'd0, ctrl}, 32'd0);
        chk("reset_mid_div_stall", STALL_CYCLES, 32'd0);
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        chk("after_reset_idle", {24'd0, last}, 32'd0);
        EX_IS_DIV = 1;
        stall_len = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (last[7]) stall_len++;
            else break;
        end
        EX_IS_DIV = 0;
        chk("div_after_reset_len", stall_len, 32'd32);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            IMEM_BUSYWAIT   = ($urandom_range(0, 99) < 6);
            DMEM_BUSYWAIT   = ($urandom_range(0, 99) < 8);
            EX_IS_MUL       = ($urandom_range(0, 99) < 8);
            EX_IS_DIV       = !EX_IS_MUL && ($urandom_range(0, 99) < 3);
            EX_BRANCH_TAKEN = ($urandom_range(0, 99) < 15);
            EX_MEMREAD      = ($urandom_range(0, 99) < 35);
            EX_RD           = 5'($urandom_range(0, 3));
            ID_RS1          = 5'($urandom_range(0, 3));
            ID_RS2          = 5'($urandom_range(0, 3));
            ID_USES_RS1     = 1'($urandom_range(0, 1));
            ID_USES_RS2     = 1'($urandom_range(0, 1));
            RESET           = ($urandom_range(0, 199) == 0);
            tick();
        end
        RESET = 1'b0;
        clear_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
